// File: rtl/host_arbiter_if.sv
// Requester-side and bridge-side signals of the host arbiter, bundled as one interface.
// master = requesters plus bridge (the environment); slave = the arbiter itself.
interface host_arbiter_if #(
    parameter int NUM_REQ        = 2,
    parameter int HOST_ADDR_BITS = 8,
    parameter int HOST_DATA_BITS = 32
);
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_opcode;
    logic [NUM_REQ*HOST_ADDR_BITS-1:0] req_addr;
    logic [NUM_REQ*HOST_DATA_BITS-1:0] req_value;
    logic [NUM_REQ-1:0]                req_deq;
    logic [NUM_REQ-1:0]                resp_valid;
    logic [HOST_DATA_BITS-1:0]         resp_bits;
    logic                              resp_err;
    logic                              host_req_valid;
    logic                              host_req_opcode;
    logic [HOST_ADDR_BITS-1:0]         host_req_addr;
    logic [HOST_DATA_BITS-1:0]         host_req_value;
    logic                              host_req_deq;
    logic                              host_resp_valid;
    logic [HOST_DATA_BITS-1:0]         host_resp_bits;

    modport slave (
        input  req_valid, req_opcode, req_addr, req_value,
        input  host_req_deq, host_resp_valid, host_resp_bits,
        output req_deq, resp_valid, resp_bits, resp_err,
        output host_req_valid, host_req_opcode, host_req_addr, host_req_value
    );

    modport master (
        output req_valid, req_opcode, req_addr, req_value,
        output host_req_deq, host_resp_valid, host_resp_bits,
        input  req_deq, resp_valid, resp_bits, resp_err,
        input  host_req_valid, host_req_opcode, host_req_addr, host_req_value
    );
endinterface

// File: rtl/host_arbiter.sv
// Round-robin arbiter sharing one host request/response port among NUM_REQ requesters,
// with a read-response timeout that answers ERR_DATA so a hung slave cannot block others.
module host_arbiter #(
    parameter int                        NUM_REQ        = 2,
    parameter int                        HOST_ADDR_BITS = 8,
    parameter int                        HOST_DATA_BITS = 32,
    parameter int                        RESP_TIMEOUT   = 1024,
    parameter logic [HOST_DATA_BITS-1:0] ERR_DATA       = HOST_DATA_BITS'(32'hDEADBEEF)
) (
    input  logic          clock,
    input  logic          reset_n,
    host_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = (RESP_TIMEOUT > 0) ? TW'(RESP_TIMEOUT - 1) : '0;
    localparam logic [IW:0]   NUM_REQ_W  = (IW + 1)'(NUM_REQ);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t                    r_state;
    logic [IW-1:0]             r_rr_ptr;
    logic [IW-1:0]             r_gid;
    logic                      r_opcode;
    logic [HOST_ADDR_BITS-1:0] r_addr;
    logic [HOST_DATA_BITS-1:0] r_value;
    logic                      r_host_req_valid;
    logic [TW-1:0]             r_timer;

    logic [IW-1:0]             w_cand [NUM_REQ];
    logic [HOST_ADDR_BITS-1:0] w_addr_arr [NUM_REQ];
    logic [HOST_DATA_BITS-1:0] w_value_arr [NUM_REQ];
    logic [NUM_REQ-1:0]        w_gid_onehot;
    logic                      w_any;
    logic [IW-1:0]             w_win;
    logic                      w_timeout;
    logic                      w_resp_data;
    logic                      w_resp_fire;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW:0] s);
        logic [IW:0] t;
        t = (s >= NUM_REQ_W) ? (s - NUM_REQ_W) : s;
        return t[IW-1:0];
    endfunction

    // w_cand[k] is the requester examined k-th, starting from the round-robin pointer
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_cand[gi]       = wrap_idx({1'b0, r_rr_ptr} + (IW + 1)'(gi));
            assign w_addr_arr[gi]   = bus.req_addr[gi*HOST_ADDR_BITS +: HOST_ADDR_BITS];
            assign w_value_arr[gi]  = bus.req_value[gi*HOST_DATA_BITS +: HOST_DATA_BITS];
            assign w_gid_onehot[gi] = (r_gid == IW'(gi));
        end
    endgenerate

    // Walk candidates from last to first so the earliest one in search order wins
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[w_cand[k]]) begin
                w_any = 1'b1;
                w_win = w_cand[k];
            end
        end
    end

    assign w_timeout   = (RESP_TIMEOUT != 0) && (r_timer == TIMER_LAST);
    assign w_resp_data = (r_state == ST_WAIT) && bus.host_resp_valid;
    assign w_resp_fire = (r_state == ST_WAIT) && (bus.host_resp_valid || w_timeout);

    assign bus.host_req_valid  = r_host_req_valid;
    assign bus.host_req_opcode = r_opcode;
    assign bus.host_req_addr   = r_addr;
    assign bus.host_req_value  = r_value;

    assign bus.req_deq    = ((r_state == ST_ISSUE) && bus.host_req_deq) ? w_gid_onehot : '0;
    assign bus.resp_valid = w_resp_fire ? w_gid_onehot : '0;
    assign bus.resp_bits  = w_resp_data ? bus.host_resp_bits : (w_resp_fire ? ERR_DATA : '0);
    assign bus.resp_err   = w_resp_fire && !bus.host_resp_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_rr_ptr         <= '0;
            r_gid            <= '0;
            r_opcode         <= 1'b0;
            r_addr           <= '0;
            r_value          <= '0;
            r_host_req_valid <= 1'b0;
            r_timer          <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gid            <= w_win;
                        r_opcode         <= bus.req_opcode[w_win];
                        r_addr           <= w_addr_arr[w_win];
                        r_value          <= w_value_arr[w_win];
                        r_rr_ptr         <= wrap_idx({1'b0, w_win} + (IW + 1)'(1));
                        r_host_req_valid <= 1'b1;
                        r_state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.host_req_deq) begin
                        r_host_req_valid <= 1'b0;
                        r_timer          <= '0;
                        // Writes complete in the bridge; only reads wait for data here
                        r_state          <= r_opcode ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_resp_fire) begin
                        r_state <= ST_IDLE;
                    end else if (r_timer != TIMER_LAST) begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state          <= ST_IDLE;
                    r_host_req_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_host_arbiter.sv
// Bench for host_arbiter: directed scenarios plus randomized traffic, all outputs compared
// each cycle against a transaction-level model of the arbitration and response rules.
module tb_host_arbiter;
    localparam int N  = 3;
    localparam int AB = 8;
    localparam int DB = 32;
    localparam int T  = 16;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    host_arbiter_if #(.NUM_REQ(N), .HOST_ADDR_BITS(AB), .HOST_DATA_BITS(DB)) bus ();

    host_arbiter #(
        .NUM_REQ(N), .HOST_ADDR_BITS(AB), .HOST_DATA_BITS(DB),
        .RESP_TIMEOUT(T), .ERR_DATA(ERR)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Model: 0 = nobody granted, 1 = request offered to bridge, 2 = waiting for read data
    int          m_phase, m_owner, m_start, m_waited;
    logic        m_op;
    logic [7:0]  m_addr;
    logic [31:0] m_val;
    bit          m_fire;
    int          ev_deq;
    bit          auto_clear = 1'b1;

    logic [N-1:0] o_deq, o_rv;
    logic [31:0]  o_bits, o_val;
    logic [7:0]   o_addr;
    logic         o_err, o_hrv;
    int           deq_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input bit v, input bit op, input logic [7:0] a,
                           input logic [31:0] d);
        bus.req_valid[i]            = v;
        bus.req_opcode[i]           = op;
        bus.req_addr[i*AB +: AB]    = a;
        bus.req_value[i*DB +: DB]   = d;
    endtask

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_start = 0; m_waited = 0;
        m_op = 1'b0; m_addr = '0; m_val = '0; ev_deq = -1;
    endtask

    // Called at posedge+1 with inputs already driven; checks at negedge, advances model at posedge
    task automatic step();
        logic [N-1:0] e_deq, e_rv;
        logic [31:0]  e_bits;
        logic         e_err;
        bit           found;
        int           c;
        @(negedge clock);
        e_deq  = (m_phase == 1 && bus.host_req_deq) ? (N'(1) << m_owner) : '0;
        m_fire = (m_phase == 2) && (bus.host_resp_valid || m_waited == T - 1);
        e_rv   = m_fire ? (N'(1) << m_owner) : '0;
        e_bits = !m_fire ? 32'h0 : (bus.host_resp_valid ? bus.host_resp_bits : ERR);
        e_err  = m_fire && !bus.host_resp_valid;
        chk("host_req_valid", bus.host_req_valid, m_phase == 1);
        if (m_phase == 1) begin
            chk("host_req_opcode", bus.host_req_opcode, m_op);
            chk("host_req_addr", bus.host_req_addr, m_addr);
            chk("host_req_value", bus.host_req_value, m_val);
        end
        chk("req_deq", bus.req_deq, e_deq);
        chk("resp_valid", bus.resp_valid, e_rv);
        chk("resp_bits", bus.resp_bits, e_bits);
        chk("resp_err", bus.resp_err, e_err);
        o_deq = bus.req_deq; o_rv = bus.resp_valid; o_bits = bus.resp_bits;
        o_err = bus.resp_err; o_hrv = bus.host_req_valid;
        o_addr = bus.host_req_addr; o_val = bus.host_req_value;
        for (int i = 0; i < N; i++) if (bus.req_deq[i]) deq_log.push_back(i);
        @(posedge clock);
        ev_deq = -1;
        case (m_phase)
            0: begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    c = (m_start + k) % N;
                    if (!found && bus.req_valid[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                        m_op    = bus.req_opcode[c];
                        m_addr  = bus.req_addr[c*AB +: AB];
                        m_val   = bus.req_value[c*DB +: DB];
                        m_start = (c + 1) % N;
                        m_phase = 1;
                    end
                end
            end
            1: if (bus.host_req_deq) begin
                ev_deq = m_owner;
                if (m_op) m_phase = 0;
                else begin m_phase = 2; m_waited = 0; end
            end
            default: if (m_fire) m_phase = 0; else m_waited++;
        endcase
        #1;
        if (auto_clear && ev_deq >= 0) bus.req_valid[ev_deq] = 1'b0;
    endtask

    // Asserts reset mid-cycle with hostile inputs, releases it at a negedge
    task automatic do_reset();
        reset_n = 1'b0;
        bus.req_valid = '0;
        bus.host_req_deq = 1'b1;
        bus.host_resp_valid = 1'b1;
        bus.host_resp_bits = 32'h1357_9BDF;
        #2;
        chk("rst_host_req_valid", bus.host_req_valid, 0);
        chk("rst_host_req_opcode", bus.host_req_opcode, 0);
        chk("rst_host_req_addr", bus.host_req_addr, 0);
        chk("rst_host_req_value", bus.host_req_value, 0);
        chk("rst_req_deq", bus.req_deq, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_bits", bus.resp_bits, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("rel_host_req_valid", bus.host_req_valid, 0);
        chk("rel_resp_valid", bus.resp_valid, 0);
        chk("rel_req_deq", bus.req_deq, 0);
        model_reset();
        @(posedge clock);
        #1;
        bus.host_req_deq = 1'b0;
        bus.host_resp_valid = 1'b0;
    endtask

    int exp2[4] = '{0, 1, 0, 1};

    initial begin
        int n0, cnt;
        bit seen;
        bit [N-1:0] pend;
        bus.req_valid = '0; bus.req_opcode = '0; bus.req_addr = '0; bus.req_value = '0;
        bus.host_req_deq = 1'b0; bus.host_resp_valid = 1'b0; bus.host_resp_bits = '0;
        model_reset();
        @(posedge clock);
        #1;
        do_reset();

        // 1: single read from requester 0
        n0 = deq_log.size();
        set_req(0, 1, 0, 8'h10, 32'h0);
        step(); step();
        bus.host_req_deq = 1'b1; step(); bus.host_req_deq = 1'b0;
        step(); step();
        bus.host_resp_valid = 1'b1; bus.host_resp_bits = 32'h5; step();
        bus.host_resp_valid = 1'b0;
        chk("t1_resp_valid", o_rv, 3'b001);
        chk("t1_resp_bits", o_bits, 32'h5);
        chk("t1_resp_err", o_err, 0);
        chk("t1_deq_count", deq_log.size() - n0, 1);

        // 2: contention from reset, twice
        do_reset();
        deq_log.delete();
        for (int r = 0; r < 2; r++) begin
            set_req(0, 1, 1, 8'h20, 32'h11);
            set_req(1, 1, 1, 8'h21, 32'h22);
            for (int c = 0; c < 12; c++) begin
                bus.host_req_deq = (m_phase == 1);
                step();
            end
            bus.host_req_deq = 1'b0;
        end
        chk("t2_grants", deq_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < deq_log.size()) chk("t2_order", deq_log[i], exp2[i]);

        // 3: write pass-through from requester 1
        set_req(1, 1, 1, 8'h04, 32'hA5A5A5A5);
        step();
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t3_addr", o_addr, 8'h04);
            chk("t3_value", o_val, 32'hA5A5A5A5);
        end
        bus.host_req_deq = 1'b1; step(); bus.host_req_deq = 1'b0;
        chk("t3_req_deq", o_deq, 3'b010);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("t3_no_resp", o_rv, 0);
        end

        // 4: read timeout from requester 1, then a stray late response
        set_req(1, 1, 0, 8'h30, 32'h0);
        step();
        bus.host_req_deq = 1'b1; step(); bus.host_req_deq = 1'b0;
        cnt = 0; seen = 1'b0;
        while (!seen && cnt < 40) begin
            step(); cnt++;
            seen = (o_rv != 0);
        end
        chk("t4_latency", cnt, 16);
        chk("t4_resp_valid", o_rv, 3'b010);
        chk("t4_resp_bits", o_bits, ERR);
        chk("t4_resp_err", o_err, 1);
        bus.host_resp_valid = 1'b1; bus.host_resp_bits = 32'h77; step();
        bus.host_resp_valid = 1'b0;
        chk("t4_stray", o_rv, 0);

        // 5: response lands exactly in the timeout cycle
        set_req(0, 1, 0, 8'h31, 32'h0);
        step();
        bus.host_req_deq = 1'b1; step(); bus.host_req_deq = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            chk("t5_early", o_rv, 0);
        end
        bus.host_resp_valid = 1'b1; bus.host_resp_bits = 32'h1234; step();
        bus.host_resp_valid = 1'b0;
        chk("t5_resp_valid", o_rv, 3'b001);
        chk("t5_resp_bits", o_bits, 32'h1234);
        chk("t5_resp_err", o_err, 0);

        // 6: reset while waiting for read data, then a fresh read
        set_req(0, 1, 0, 8'h40, 32'h0);
        step();
        bus.host_req_deq = 1'b1; step(); bus.host_req_deq = 1'b0;
        step(); step(); step();
        do_reset();
        set_req(0, 1, 0, 8'h44, 32'h0);
        step();
        chk("t6_granted", bus.host_req_valid, 1);
        bus.host_req_deq = 1'b1; step(); bus.host_req_deq = 1'b0;
        chk("t6_req_deq", o_deq, 3'b001);
        bus.host_resp_valid = 1'b1; bus.host_resp_bits = 32'hCAFE; step();
        bus.host_resp_valid = 1'b0;
        chk("t6_resp_valid", o_rv, 3'b001);
        chk("t6_resp_bits", o_bits, 32'hCAFE);

        // Randomized traffic; the granted requester may drop req_valid before deq
        auto_clear = 1'b0;
        pend = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(499) == 0) begin
                do_reset();
                pend = '0;
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(3) == 0) begin
                    pend[i] = 1'b1;
                    set_req(i, 0, 1'($urandom_range(1)), 8'($urandom), $urandom);
                end
                bus.req_valid[i] = (m_phase == 1 && m_owner == i) ? 1'($urandom_range(1)) : pend[i];
            end
            bus.host_req_deq    = (m_phase == 1) && ($urandom_range(2) == 0);
            bus.host_resp_valid = (m_phase == 2) ? ($urandom_range(11) == 0) : ($urandom_range(9) == 0);
            bus.host_resp_bits  = $urandom;
            step();
            if (ev_deq >= 0) pend[ev_deq] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
